prime_scanner: RTL and testbench
================================

PRIME_SCANNER -- requirements
Module: prime_scanner

Interface
REQ-001 Parameters: none; data width is fixed at 4 bits to match the prime detector.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  scan request; sampled only in IDLE.
REQ-005 lo  input  4  first value of the scan range (inclusive).
REQ-006 hi  input  4  last value of the scan range (inclusive).
REQ-007 busy  output  1  high while state is SCAN.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 err  output  1  high when the last request had lo > hi; valid while done is high and held until the next accepted start.
REQ-010 cur  output  4  value currently presented to the prime detector.
REQ-011 count  output  3  number of primes found in the range.
REQ-012 bitmap  output  16  bit v set iff v is in range and prime.

Function
REQ-013 FSM states SHALL be IDLE, SCAN and DONE.
REQ-014 IDLE with start=1 and lo<=hi SHALL go to SCAN at the next edge, loading cur=lo and clearing count, bitmap and err.
REQ-015 IDLE with start=1 and lo>hi SHALL go directly to DONE, clearing count and bitmap and setting err=1.
REQ-016 Each SCAN cycle SHALL evaluate the detector on cur combinationally; if the detector reports prime, set bitmap[cur] and increment count at the edge.
REQ-017 In SCAN, cur!=hi SHALL increment cur; cur==hi SHALL go to DONE, with cur held at hi (no wrap, including hi=15).
REQ-018 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-019 Latency: for N=hi-lo+1 values, done SHALL be high in the cycle after edge k+N, where edge k accepts start; the error case takes one edge.
REQ-020 start SHALL be ignored in SCAN and DONE; a start held high in the IDLE cycle after DONE SHALL begin a new scan.
REQ-021 lo and hi SHALL be latched at acceptance; later changes on the inputs SHALL have no effect on a scan in progress.
REQ-022 count, bitmap and err SHALL hold their values in IDLE until the next accepted start.
REQ-023 count SHALL never exceed 6; no saturation logic is required.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, err=0, cur=0, count=0 and bitmap=0, regardless of clk.
REQ-025 Reset asserted during SCAN SHALL abort the scan with no done pulse; the first start after release SHALL behave as in REQ-014/015.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE, SCAN, DONE) and the constants PRIME_W=4 and PRIME_MAX_CNT=6.
REQ-027 The design SHALL contain exactly one sub-module: the existing combinational detector prime, with cur[3] driven to a, cur[2] to b, cur[1] to c and cur[0] to d, and out used as the prime flag.

Verification
REQ-028 lo=0, hi=15, start pulse -> busy for 16 cycles; done after 17 edges; count=6, bitmap=16'h28AC, err=0.
REQ-029 lo=hi=13 -> done after 2 edges; count=1, bitmap=16'h2000. lo=hi=9 -> count=0, bitmap=0.
REQ-030 lo=10, hi=3 -> done after 1 edge, err=1, count=0, bitmap=0, busy never asserted.
REQ-031 lo=12, hi=15 -> cur steps 12,13,14,15 then holds at 15, no wrap to 0; count=1, bitmap=16'h2000.
REQ-032 Start lo=0, hi=15, pulse start again mid-scan and change lo/hi -> the second start and the input changes are ignored, results match REQ-028; start held high through DONE -> a second scan starts.
REQ-033 rst_n asynchronous low at SCAN cycle 5 -> all outputs 0 with no clk edge needed, no done pulse; a following scan with lo=2, hi=7 -> count=4, bitmap=16'h00AC.

Source files
------------

// File: rtl/prime_scanner_pkg.sv
// Shared types and constants for the prime range scanner.
// The detector and the scanner both work on 4-bit values (0..15).
package prime_scanner_pkg;

    localparam int PRIME_W       = 4;
    localparam int PRIME_MAX_CNT = 6;
    localparam int PRIME_CNT_W   = 3;
    localparam int PRIME_SPAN    = 1 << PRIME_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // A request is scannable only when the range is non-empty.
    function automatic logic range_valid(input logic [PRIME_W-1:0] lo,
                                         input logic [PRIME_W-1:0] hi);
        return (lo <= hi);
    endfunction

endpackage

// File: rtl/prime_scanner_if.sv
// Request/result bundle between a scan requester and prime_scanner.
// The debug state field lets checkers observe the FSM directly.
interface prime_scanner_if;
    import prime_scanner_pkg::*;

    // start is a request qualified only while the scanner is IDLE (busy=0, done=0);
    // results (count, bitmap, err) are valid in the done cycle and held until the next accepted start.
    logic                   start;
    logic [PRIME_W-1:0]     lo;
    logic [PRIME_W-1:0]     hi;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [PRIME_W-1:0]     cur;
    logic [PRIME_CNT_W-1:0] count;
    logic [PRIME_SPAN-1:0]  bitmap;
    state_t                 state;

    modport master (
        output start,
        output lo,
        output hi,
        input  busy,
        input  done,
        input  err,
        input  cur,
        input  count,
        input  bitmap,
        input  state
    );

    modport slave (
        input  start,
        input  lo,
        input  hi,
        output busy,
        output done,
        output err,
        output cur,
        output count,
        output bitmap,
        output state
    );

endinterface

// File: rtl/prime_scanner_prime.sv
// Existing combinational 4-bit prime detector: out=1 for 2, 3, 5, 7, 11, 13.
// Inputs are the value bits MSB-first (a is bit 3, d is bit 0).
module prime (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic out
);

    assign out = (~a & ~b &  c)
               | (~a &  b &  d)
               | ( b & ~c &  d)
               | (~b &  c &  d);

endmodule

// File: rtl/prime_scanner.sv
// Walks cur from lo to hi one value per cycle, recording which values are prime.
// Produces a one-cycle done pulse with count/bitmap/err held until the next request.
module prime_scanner
    import prime_scanner_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    prime_scanner_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_SCAN = SCAN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]             state_q;
    logic [PRIME_W-1:0]     cur_q;
    logic [PRIME_W-1:0]     hi_q;
    logic [PRIME_CNT_W-1:0] count_q;
    logic [PRIME_SPAN-1:0]  bitmap_q;
    logic                   err_q;
    logic                   is_prime;
    logic                   at_last;

    prime u_prime (
        .a   (cur_q[3]),
        .b   (cur_q[2]),
        .c   (cur_q[1]),
        .d   (cur_q[0]),
        .out (is_prime)
    );

    // hi is latched at acceptance so the end test ignores later input changes.
    assign at_last = (cur_q == hi_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cur_q    <= '0;
            hi_q     <= '0;
            count_q  <= '0;
            bitmap_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        count_q  <= '0;
                        bitmap_q <= '0;
                        if (range_valid(bus.lo, bus.hi)) begin
                            state_q <= ST_SCAN;
                            cur_q   <= bus.lo;
                            hi_q    <= bus.hi;
                            err_q   <= 1'b0;
                        end else begin
                            state_q <= ST_DONE;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    if (is_prime) begin
                        bitmap_q[cur_q] <= 1'b1;
                        count_q         <= count_q + 3'd1;
                    end
                    // cur stays at hi on the last value so hi=15 never wraps to 0.
                    if (at_last) begin
                        state_q <= ST_DONE;
                    end else begin
                        cur_q <= cur_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = (state_q == ST_SCAN);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.err    = err_q;
    assign bus.cur    = cur_q;
    assign bus.count  = count_q;
    assign bus.bitmap = bitmap_q;
    assign bus.state  = state_t'(state_q);

endmodule

// File: tb/tb_prime_scanner.sv
// Bench for prime_scanner: a queue-based cycle model derived from the range rules,
// directed requests, and a literal result table per done pulse.
module tb_prime_scanner;
    import prime_scanner_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    prime_scanner_if bus();

    prime_scanner dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic        busy;
        logic        done;
        logic        chk_cur;
        logic [3:0]  cur;
        logic [2:0]  count;
        logic [15:0] bitmap;
        logic        err;
    } exp_t;

    int checks = 0;
    int errors = 0;

    exp_t        exp_q[$];
    logic [2:0]  held_count;
    logic [15:0] held_bm;
    logic        held_err;
    logic [3:0]  held_cur;
    bit          cur_known;
    bit          last_rst;
    int          done_idx = 0;

    // Hand-computed results, one entry per expected done pulse, in request order.
    int          lit_cnt[9] = '{6, 1, 0, 0, 1, 6, 3, 2, 4};
    logic [15:0] lit_bm[9]  = '{16'h28AC, 16'h2000, 16'h0000, 16'h0000, 16'h2000,
                                16'h28AC, 16'h002C, 16'h2800, 16'h00AC};
    bit          lit_err[9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_prime_int(input int v);
        if (v < 2) return 1'b0;
        for (int d = 2; d * d <= v; d++) begin
            if (v % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Expand one accepted request into the cycle-by-cycle trace that must follow it.
    task automatic predict(input logic [3:0] l, input logic [3:0] h);
        exp_t e;
        int   c;
        logic [15:0] bm;
        c  = 0;
        bm = '0;
        if (int'(l) > int'(h)) begin
            e = '{st: DONE, busy: 1'b0, done: 1'b1, chk_cur: 1'b0, cur: 4'd0,
                  count: 3'd0, bitmap: 16'h0, err: 1'b1};
            exp_q.push_back(e);
        end else begin
            for (int v = int'(l); v <= int'(h); v++) begin
                e = '{st: SCAN, busy: 1'b1, done: 1'b0, chk_cur: 1'b1, cur: v[3:0],
                      count: c[2:0], bitmap: bm, err: 1'b0};
                exp_q.push_back(e);
                if (is_prime_int(v)) begin
                    c++;
                    bm[v] = 1'b1;
                end
            end
            e = '{st: DONE, busy: 1'b0, done: 1'b1, chk_cur: 1'b1, cur: h,
                  count: c[2:0], bitmap: bm, err: 1'b0};
            exp_q.push_back(e);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy",   bus.busy,   0);
        chk("rst_done",   bus.done,   0);
        chk("rst_err",    bus.err,    0);
        chk("rst_cur",    bus.cur,    0);
        chk("rst_count",  bus.count,  0);
        chk("rst_bitmap", bus.bitmap, 0);
        chk("rst_state",  bus.state,  IDLE);
    endtask

    // Model and compare process: one check set per falling clock edge.
    initial begin
        exp_t e;
        bit   was_idle;
        last_rst   = 1'b1;
        held_count = '0;
        held_bm    = '0;
        held_err   = 1'b0;
        held_cur   = '0;
        cur_known  = 1'b1;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                if (last_rst) begin
                    last_rst = 1'b0;
                    exp_q.delete();
                    held_count = '0;
                    held_bm    = '0;
                    held_err   = 1'b0;
                    held_cur   = '0;
                    cur_known  = 1'b1;
                    #1;
                    check_reset_outputs();
                end
                continue;
            end
            last_rst = 1'b1;
            was_idle = (exp_q.size() == 0);
            if (was_idle) begin
                chk("idle_busy",   bus.busy,   0);
                chk("idle_done",   bus.done,   0);
                chk("idle_state",  bus.state,  IDLE);
                chk("idle_count",  bus.count,  held_count);
                chk("idle_bitmap", bus.bitmap, held_bm);
                chk("idle_err",    bus.err,    held_err);
                if (cur_known) chk("idle_cur", bus.cur, held_cur);
            end else begin
                e = exp_q.pop_front();
                chk("busy",  bus.busy,  e.busy);
                chk("done",  bus.done,  e.done);
                chk("state", bus.state, e.st);
                chk("count", bus.count, e.count);
                chk("bitmap", bus.bitmap, e.bitmap);
                if (e.done) chk("err", bus.err, e.err);
                if (e.chk_cur) chk("cur", bus.cur, e.cur);
                if (e.done) begin
                    held_count = e.count;
                    held_bm    = e.bitmap;
                    held_err   = e.err;
                    held_cur   = e.cur;
                    cur_known  = e.chk_cur;
                    if (done_idx < 9) begin
                        chk("lit_count",  bus.count,  lit_cnt[done_idx]);
                        chk("lit_bitmap", bus.bitmap, lit_bm[done_idx]);
                        chk("lit_err",    bus.err,    lit_err[done_idx]);
                    end
                    done_idx++;
                end
            end
            if (was_idle && bus.start) predict(bus.lo, bus.hi);
        end
    end

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done pulse, expected one within 40 cycles at %0t", $time);
    endtask

    task automatic run_req(input logic [3:0] l, input logic [3:0] h);
        @(posedge clk); #1;
        bus.lo    = l;
        bus.hi    = h;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.lo    = 4'd0;
        bus.hi    = 4'd0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_req(4'd0,  4'd15);
        run_req(4'd13, 4'd13);
        run_req(4'd9,  4'd9);
        run_req(4'd10, 4'd3);
        run_req(4'd12, 4'd15);

        // Start pulses and range changes during a scan must be ignored.
        @(posedge clk); #1;
        bus.lo = 4'd0; bus.hi = 4'd15; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.lo = 4'd5; bus.hi = 4'd6;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.lo = 4'd9; bus.hi = 4'd2;
        wait_done();

        // start held high through DONE launches a back-to-back scan.
        @(posedge clk); #1;
        bus.lo = 4'd2; bus.hi = 4'd5; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.lo = 4'd11; bus.hi = 4'd13;
        wait_done();
        @(posedge clk);
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done();

        // Asynchronous reset in the fifth scan cycle aborts without a done pulse.
        @(posedge clk); #1;
        bus.lo = 4'd0; bus.hi = 4'd15; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        run_req(4'd2, 4'd7);

        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", done_idx, 9);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected one before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
